// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light controller: phase encoding and
// the width helper used to size way indices.
package semaforo_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  // Ceiling log2, clamped to 1 so a way index is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/semaforo_rr.sv
// Round-robin approach selector: first requesting way strictly after cur_way,
// wrapping around; cur_way itself has the lowest priority.
module semaforo_rr
  import semaforo_pkg::*;
#(
  parameter int N_WAYS = 4
) (
  input  logic [N_WAYS-1:0]         req,
  input  logic [clog2(N_WAYS)-1:0]  cur_way,
  output logic [clog2(N_WAYS)-1:0]  next_way,
  output logic                      any_req
);

  localparam int WW = clog2(N_WAYS);
  localparam logic [WW-1:0] LAST = WW'(N_WAYS - 1);

  logic [WW-1:0] ptr;
  logic          found;

  always_comb begin
    next_way = cur_way;
    any_req  = |req;
    ptr      = cur_way;
    found    = 1'b0;
    // Walk the ring once; the pointer wraps explicitly so non-power-of-two
    // way counts never index past the last approach.
    for (int i = 0; i < N_WAYS; i++) begin
      ptr = (ptr == LAST) ? '0 : ptr + 1'b1;
      if (!found && req[ptr]) begin
        next_way = ptr;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light phase controller: ALLRED -> GREEN -> YELLOW cycle with green
// extension, round-robin service and emergency preemption. All lamps registered.
module semaforo_ctrl
  import semaforo_pkg::*;
#(
  parameter int N_WAYS   = 4,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 2,
  parameter int TW       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_WAYS-1:0]         req,
  input  logic                      emerg,
  input  logic [clog2(N_WAYS)-1:0]  emerg_way,
  output logic [N_WAYS-1:0]         green,
  output logic [N_WAYS-1:0]         yellow,
  output logic [N_WAYS-1:0]         red,
  output logic [clog2(N_WAYS)-1:0]  cur_way
);

  localparam int WW = clog2(N_WAYS);
  localparam logic [TW-1:0] LD_G = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] LD_Y = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] LD_A = TW'(T_ALLRED - 1);
  localparam logic [WW-1:0] LAST = WW'(N_WAYS - 1);
  localparam logic [WW:0]   NW   = (WW+1)'(N_WAYS);

  function automatic logic [N_WAYS-1:0] onehot(input logic [WW-1:0] w);
    logic [N_WAYS-1:0] r;
    r    = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [WW-1:0]     way_nxt;
  logic [WW-1:0]     rr_way;
  logic              rr_any;
  logic              em_ok;
  logic              other_req;
  logic [N_WAYS-1:0] green_nxt, yellow_nxt;

  semaforo_rr #(.N_WAYS(N_WAYS)) u_rr (
    .req      (req),
    .cur_way  (cur_way),
    .next_way (rr_way),
    .any_req  (rr_any)
  );

  // An out-of-range emergency way is treated as no emergency at all.
  assign em_ok     = emerg && ({1'b0, emerg_way} < NW);
  assign other_req = |(req & ~onehot(cur_way));

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    way_nxt   = cur_way;
    unique case (state)
      ALLRED: begin
        if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else if (em_ok) begin
          state_nxt = GREEN;
          way_nxt   = emerg_way;
          timer_nxt = LD_G;
        end else if (rr_any) begin
          state_nxt = GREEN;
          way_nxt   = rr_way;
          timer_nxt = LD_G;
        end else begin
          timer_nxt = '0;
        end
      end
      GREEN: begin
        if (em_ok && (emerg_way != cur_way)) begin
          state_nxt = YELLOW;
          timer_nxt = LD_Y;
        end else if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else if (!em_ok && other_req) begin
          state_nxt = YELLOW;
          timer_nxt = LD_Y;
        end else begin
          // Extension: either nobody else is waiting or the emergency is ours.
          timer_nxt = '0;
        end
      end
      YELLOW: begin
        if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else begin
          state_nxt = ALLRED;
          timer_nxt = LD_A;
        end
      end
      default: begin
        state_nxt = ALLRED;
        timer_nxt = LD_A;
      end
    endcase
  end

  // Lamp decode from the next state so the lamps change on the same edge
  // as the phase itself.
  always_comb begin
    green_nxt  = (state_nxt == GREEN)  ? onehot(way_nxt) : '0;
    yellow_nxt = (state_nxt == YELLOW) ? onehot(way_nxt) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ALLRED;
      timer   <= LD_A;
      cur_way <= LAST;
      green   <= '0;
      yellow  <= '0;
      red     <= '1;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      cur_way <= way_nxt;
      green   <= green_nxt;
      yellow  <= yellow_nxt;
      red     <= ~(green_nxt | yellow_nxt);
    end
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Scenario bench for semaforo_ctrl (4 ways, green 5, yellow 2, all-red 1):
// expected lamp states queued per cycle, compared one edge later.
module tb_semaforo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       emerg = 1'b0;
  logic [1:0] emerg_way = '0;
  logic [3:0] green, yellow, red;
  logic [1:0] cur_way;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] cw;
  } exp_t;

  exp_t sb[$];
  logic [3:0] prev_g = '0;

  semaforo_ctrl #(
    .N_WAYS(4), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1), .TW(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .emerg     (emerg),
    .emerg_way (emerg_way),
    .green     (green),
    .yellow    (yellow),
    .red       (red),
    .cur_way   (cur_way)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Drive inputs for the coming edge, queue the expected outputs after it.
  task automatic cyc(input string tag, input logic [3:0] r, input logic e,
                     input logic [1:0] ew, input logic [3:0] eg,
                     input logic [3:0] ey, input logic [1:0] ecw);
    exp_t x;
    req       = r;
    emerg     = e;
    emerg_way = ew;
    sb.push_back('{g: eg, y: ey, cw: ecw});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, "_green"},  {4'h0, green},  {4'h0, x.g});
    chk({tag, "_yellow"}, {4'h0, yellow}, {4'h0, x.y});
    chk({tag, "_red"},    {4'h0, red},    {4'h0, ~(x.g | x.y)});
    chk({tag, "_way"},    {6'h0, cur_way}, {6'h0, x.cw});
  endtask

  task automatic phase(input string tag, input logic [3:0] r, input logic e,
                       input logic [1:0] ew, input logic [3:0] eg,
                       input logic [3:0] ey, input logic [1:0] ecw, input int n);
    for (int i = 0; i < n; i++) cyc(tag, r, e, ew, eg, ey, ecw);
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    phase("rst", r, 1'b0, 2'd0, 4'b0000, 4'b0000, 2'd3, 2);
    rst_n = 1'b1;
  endtask

  // Lamp invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_onehot", {7'h0, ($countones(green | yellow) <= 1)}, 8'h1);
      chk("inv_red", {4'h0, red}, {4'h0, ~(green | yellow)});
      chk("inv_g2r", {4'h0, prev_g & red}, 8'h0);
      prev_g <= green;
    end else begin
      prev_g <= '0;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
    $fatal(1);
  end

  initial begin
    #2;
    // Startup sequence with every approach requesting.
    do_reset(4'b1111);
    phase("s1_g0", 4'b1111, 0, 0, 4'b0001, 4'b0000, 2'd0, 5);
    phase("s1_y0", 4'b1111, 0, 0, 4'b0000, 4'b0001, 2'd0, 2);
    phase("s1_ar", 4'b1111, 0, 0, 4'b0000, 4'b0000, 2'd0, 1);
    phase("s1_g1", 4'b1111, 0, 0, 4'b0010, 4'b0000, 2'd1, 1);

    // Idle all-red, then a single request.
    do_reset(4'b0000);
    phase("s2_idle", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd3, 8);
    phase("s2_g2",   4'b0100, 0, 0, 4'b0100, 4'b0000, 2'd2, 3);

    // Extension on a lone request, then wrap-around to way 0.
    do_reset(4'b1000);
    phase("s3_ext", 4'b1000, 0, 0, 4'b1000, 4'b0000, 2'd3, 12);
    phase("s3_y3",  4'b1001, 0, 0, 4'b0000, 4'b1000, 2'd3, 2);
    phase("s3_ar",  4'b1001, 0, 0, 4'b0000, 4'b0000, 2'd3, 1);
    phase("s3_g0",  4'b1001, 0, 0, 4'b0001, 4'b0000, 2'd0, 1);

    // Emergency preemption of green[1] in favour of way 3.
    do_reset(4'b0010);
    phase("s4_g1",   4'b0010, 0, 0, 4'b0010, 4'b0000, 2'd1, 2);
    phase("s4_y1",   4'b0010, 1, 3, 4'b0000, 4'b0010, 2'd1, 2);
    phase("s4_ar",   4'b0010, 1, 3, 4'b0000, 4'b0000, 2'd1, 1);
    phase("s4_g3",   4'b1111, 1, 3, 4'b1000, 4'b0000, 2'd3, 10);
    phase("s4_y3",   4'b1111, 0, 0, 4'b0000, 4'b1000, 2'd3, 2);
    phase("s4_ar2",  4'b1111, 0, 0, 4'b0000, 4'b0000, 2'd3, 1);
    phase("s4_g0",   4'b1111, 0, 0, 4'b0001, 4'b0000, 2'd0, 1);

    // Dropping the served request must not cut the green short.
    do_reset(4'b0011);
    phase("s5_g0a", 4'b0011, 0, 0, 4'b0001, 4'b0000, 2'd0, 1);
    phase("s5_g0b", 4'b0010, 0, 0, 4'b0001, 4'b0000, 2'd0, 4);
    phase("s5_y0",  4'b0010, 0, 0, 4'b0000, 4'b0001, 2'd0, 2);
    phase("s5_ar",  4'b0010, 0, 0, 4'b0000, 4'b0000, 2'd0, 1);
    phase("s5_g1",  4'b0010, 0, 0, 4'b0010, 4'b0000, 2'd1, 1);

    // Asynchronous reset during yellow[2], then restart at way 0.
    do_reset(4'b1100);
    phase("s6_g2", 4'b1100, 0, 0, 4'b0100, 4'b0000, 2'd2, 5);
    phase("s6_y2", 4'b1100, 0, 0, 4'b0000, 4'b0100, 2'd2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_red",    {4'h0, red},    8'h0f);
    chk("s6_async_green",  {4'h0, green},  8'h00);
    chk("s6_async_yellow", {4'h0, yellow}, 8'h00);
    chk("s6_async_way",    {6'h0, cur_way}, 8'h03);
    phase("s6_hold", 4'b1111, 0, 0, 4'b0000, 4'b0000, 2'd3, 1);
    rst_n = 1'b1;
    phase("s6_g0", 4'b1111, 0, 0, 4'b0001, 4'b0000, 2'd0, 5);
    phase("s6_y0", 4'b1111, 0, 0, 4'b0000, 4'b0001, 2'd0, 1);

    if (sb.size() != 0) chk("sb_drain", 8'(sb.size()), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/semaforo_ctrl.md
SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

Interface
REQ-001 The block SHALL have parameter N_WAYS, default 4: number of approaches (2..8).
REQ-002 The block SHALL have parameter T_GREEN, default 20: minimum green time in clock cycles (>=1).
REQ-003 The block SHALL have parameter T_YELLOW, default 4: yellow time in clock cycles (>=1).
REQ-004 The block SHALL have parameter T_ALLRED, default 2: all-red clearance time in clock cycles (>=1).
REQ-005 The block SHALL have parameter TW, default 8: phase timer width, which SHALL hold the largest T_* value.
REQ-006 The block SHALL have port clk, input, width 1: single clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, width 1: asynchronous reset, active-low.
REQ-008 The block SHALL have port req, input, width N_WAYS: per-approach vehicle-present sensor, level, synchronous to clk.
REQ-009 The block SHALL have port emerg, input, width 1: emergency preemption request, level.
REQ-010 The block SHALL have port emerg_way, input, width clog2(N_WAYS): approach to be given priority while emerg=1.
REQ-011 The block SHALL have ports green, yellow and red, output, width N_WAYS each: one lamp bit per approach.
REQ-012 The block SHALL have port cur_way, output, width clog2(N_WAYS): approach currently green or yellow, otherwise last served.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 The FSM SHALL have the states ALLRED, GREEN and YELLOW; one down-counter SHALL time every phase.
REQ-015 On entry to a phase, the timer SHALL load the phase duration minus 1; the last cycle of the phase is the one where timer==0.
REQ-016 Lamps SHALL be on for exactly T_GREEN, T_YELLOW and T_ALLRED cycles respectively, unless extended (REQ-019) or preempted (REQ-021).
REQ-017 ALLRED, last cycle: if emerg=1, select emerg_way; else if any req, select round-robin from cur_way+1 upward with wrap; else stay in ALLRED, re-evaluating every cycle with the timer held at 0.
REQ-018 Selected way -> GREEN next cycle; cur_way SHALL update on the same edge.
REQ-019 GREEN, timer==0: if no req on another way and emerg=0, green SHALL be held (extension); otherwise -> YELLOW.
REQ-020 YELLOW, timer==0 -> ALLRED.
REQ-021 Preemption: GREEN with emerg=1 and emerg_way!=cur_way -> YELLOW on the next edge, regardless of the timer.
REQ-022 GREEN with emerg=1 and emerg_way==cur_way: green SHALL be held regardless of the timer or other requests.
REQ-023 YELLOW and ALLRED SHALL never be shortened by emerg.
REQ-024 Invariants on every cycle: at most one bit set across green|yellow; red = ~(green|yellow) bitwise; no approach goes green->red without YELLOW.
REQ-025 A req that drops during GREEN SHALL NOT shorten the green.
REQ-026 An emerg_way value >= N_WAYS SHALL be ignored, i.e. treated as emerg=0.

Reset
REQ-027 With rst_n=0, the block SHALL take asynchronously: state ALLRED, timer T_ALLRED-1, red all ones, green and yellow 0, cur_way N_WAYS-1 (so the first round-robin search starts at way 0).
REQ-028 A reset mid-phase SHALL force all-red immediately, with no yellow.
REQ-029 After rst_n deasserts, the first GREEN SHALL occur no earlier than T_ALLRED cycles later.

Structure
REQ-030 Package semaforo_pkg SHALL hold the state encoding (ALLRED/GREEN/YELLOW) and the clog2 helper function.
REQ-031 One combinational sub-module, semaforo_rr, SHALL compute the round-robin next way: inputs req and cur_way; outputs next_way and any_req.
REQ-032 The controller SHALL instantiate semaforo_rr once.

Verification
Bench parameters: N_WAYS=4, T_GREEN=5, T_YELLOW=2, T_ALLRED=1.
REQ-033 Reset held, req=4'b1111 -> red=4'b1111 throughout; release -> green[0] 1 cycle later for 5 cycles, yellow[0] for 2, 1 all-red cycle, then green[1].
REQ-034 req=4'b0000 after reset -> all-red indefinitely; raise req[2] -> green[2] within 1 cycle of the ALLRED evaluation.
REQ-035 Only req[3]=1 -> green[3] extends past 5 cycles indefinitely; raise req[0] -> yellow[3] on the next edge, then green[0] (wrap-around).
REQ-036 green[1] in cycle 2 of its phase, emerg=1, emerg_way=3 -> yellow[1] next cycle for 2 cycles, 1 all-red cycle, then green[3] held while emerg=1 even with req=4'b1111.
REQ-037 rst_n pulsed low during yellow[2] -> red=4'b1111 asynchronously; after release, the sequence restarts at way 0.
REQ-038 A checker SHALL assert REQ-024 on every cycle of every scenario.
